// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - fetch/load-store arbiter for one single-port SRAM (option: SRAM_ARB_RR_EN)
module sram_req_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic [3:0]        data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   input  logic              flush,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_t;

   owner_t resp_owner;
   owner_t resp_owner_nxt;

   logic inst_elig;
   logic data_elig;

   // A fetch during flush carries a stale address, so it is not eligible.
   // Gating with resetn keeps both grants low while reset is held.
   assign inst_elig = resetn && inst_req && !flush;
   assign data_elig = resetn && data_req;

`ifdef SRAM_ARB_RR_EN
   localparam logic RR_DATA = 1'b0;
   localparam logic RR_INST = 1'b1;

   logic rr_last;
   logic rr_last_nxt;

   // On conflict the requester that lost the previous conflict wins.
   always_comb begin
      inst_gnt    = 1'b0;
      data_gnt    = 1'b0;
      rr_last_nxt = rr_last;
      if (inst_elig && data_elig) begin
         if (rr_last == RR_DATA) begin
            inst_gnt    = 1'b1;
            rr_last_nxt = RR_INST;
         end else begin
            data_gnt    = 1'b1;
            rr_last_nxt = RR_DATA;
         end
      end else begin
         inst_gnt = inst_elig;
         data_gnt = data_elig;
      end
   end

   // Round-robin history register, only moves on conflict cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_last <= RR_DATA;
      end else begin
         rr_last <= rr_last_nxt;
      end
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   logic [3:0] starve_cnt_nxt;
   logic       inst_forced;

   // Data wins by default; a fetch denied LIMIT cycles in a row is forced through.
   always_comb begin
      inst_forced    = (starve_cnt == LIMIT);
      inst_gnt       = inst_elig && (!data_elig || inst_forced);
      data_gnt       = data_elig && !inst_gnt;
      starve_cnt_nxt = 4'd0;
      if (inst_elig && !inst_gnt) begin
         starve_cnt_nxt = inst_forced ? LIMIT : starve_cnt + 4'd1;
      end
   end

   // Consecutive-denial counter for the fetch port.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= 4'd0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
      end
   end
`endif

   // Drive the SRAM port from the winner; idle cycles present all zeros.
   always_comb begin
      sram_en    = inst_gnt | data_gnt;
      sram_we    = 4'd0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (inst_gnt) begin
         sram_addr = inst_addr;
      end else if (data_gnt) begin
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
         sram_we    = data_we;
      end
   end

   // Next response owner: reads get a response next cycle, stores do not.
   always_comb begin
      resp_owner_nxt = OWN_NONE;
      if (inst_gnt) begin
         resp_owner_nxt = OWN_INST;
      end else if (data_gnt && (data_we == 4'd0)) begin
         resp_owner_nxt = OWN_DATA;
      end
   end

   // Response owner register; reset drops any in-flight response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_owner <= OWN_NONE;
      end else begin
         resp_owner <= resp_owner_nxt;
      end
   end

   // Route read data to its owner; a flush squashes an in-flight fetch response.
   always_comb begin
      inst_rvalid = (resp_owner == OWN_INST) && !flush;
      data_rvalid = (resp_owner == OWN_DATA);
      inst_rdata  = inst_rvalid ? sram_rdata : '0;
      data_rdata  = data_rvalid ? sram_rdata : '0;
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed table-driven bench for sram_req_arbiter
module tb_sram_req_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        flush;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int tests;
   int fails;

   sram_req_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .inst_req(inst_req),
      .inst_addr(inst_addr),
      .inst_gnt(inst_gnt),
      .inst_rvalid(inst_rvalid),
      .inst_rdata(inst_rdata),
      .data_req(data_req),
      .data_we(data_we),
      .data_addr(data_addr),
      .data_wdata(data_wdata),
      .data_gnt(data_gnt),
      .data_rvalid(data_rvalid),
      .data_rdata(data_rdata),
      .flush(flush),
      .sram_en(sram_en),
      .sram_we(sram_we),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic [3:0]  dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic        fl;
      logic        ig;
      logic        dg;
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        irv;
      logic        drv;
   } vec_t;

   localparam int NV = 29;
   vec_t vec [NV];

   task automatic check(input string name, input logic [136:0] got, input logic [136:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [136:0] got;
      logic [136:0] exp;

      tests = 0;
      fails = 0;

      //          ir    ia            dr    dwe   da            dwd           fl    ig    dg    en    we    addr          wd            irv   drv
      vec[0]  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0};
      vec[1]  = '{1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000000, 32'h0,        1'b0, 1'b0};
      vec[2]  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};
      vec[3]  = '{1'b0, 32'h0,        1'b1, 4'h3, 32'h200,      32'hdeadbeef, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h200,      32'hdeadbeef, 1'b0, 1'b0};
      vec[4]  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0};
      vec[5]  = '{1'b1, 32'h1c000004, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b0};
      vec[6]  = '{1'b1, 32'h1c000004, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b1};
      vec[7]  = vec[6];
      vec[8]  = vec[6];
      vec[9]  = '{1'b1, 32'h1c000004, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000004, 32'h0,        1'b0, 1'b1};
      vec[10] = '{1'b1, 32'h1c000004, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100,      32'h0,        1'b1, 1'b0};
      vec[11] = '{1'b1, 32'h1c000008, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000008, 32'h0,        1'b0, 1'b1};
      vec[12] = '{1'b1, 32'h1c00000c, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0};
      vec[13] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0};
      vec[14] = '{1'b1, 32'h1c000010, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000010, 32'h0,        1'b0, 1'b0};
      vec[15] = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h300,      32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h300,      32'h0,        1'b0, 1'b0};
      vec[16] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
      vec[17] = '{1'b1, 32'h40,       1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h40,       32'h0,        1'b0, 1'b0};
      vec[18] = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h44,       32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h44,       32'h0,        1'b1, 1'b0};
      vec[19] = '{1'b1, 32'h48,       1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h48,       32'h0,        1'b0, 1'b1};
      vec[20] = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h4c,       32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h4c,       32'h0,        1'b1, 1'b0};
      vec[21] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
      // fetch blocked by flush must not advance the starvation count
      vec[22] = '{1'b1, 32'h1c000020, 1'b1, 4'h0, 32'h100,      32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b0};
      for (int k = 23; k <= 26; k++)
         vec[k] = '{1'b1, 32'h1c000020, 1'b1, 4'h0, 32'h100,    32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b1};
      vec[27] = '{1'b1, 32'h1c000020, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000020, 32'h0,        1'b0, 1'b1};
      vec[28] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};

      // reset state: requests present, nothing granted or valid
      resetn     = 1'b0;
      inst_req   = 1'b1;
      inst_addr  = 32'h1c000000;
      data_req   = 1'b1;
      data_we    = 4'h0;
      data_addr  = 32'h100;
      data_wdata = 32'h0;
      flush      = 1'b0;
      sram_rdata = 32'h12345678;
      #3;
      check("reset_state", {inst_gnt, data_gnt, sram_en, inst_rvalid, data_rvalid},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      resetn   = 1'b1;
      inst_req = 1'b0;
      data_req = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge clk);
         rd         = 32'ha0000000 + 32'(i);
         inst_req   = vec[i].ir;
         inst_addr  = vec[i].ia;
         data_req   = vec[i].dr;
         data_we    = vec[i].dwe;
         data_addr  = vec[i].da;
         data_wdata = vec[i].dwd;
         flush      = vec[i].fl;
         sram_rdata = rd;
         #1;
         got = {inst_gnt, data_gnt, sram_en, sram_we, sram_addr, sram_wdata,
                inst_rvalid, inst_rdata, data_rvalid, data_rdata};
         exp = {vec[i].ig, vec[i].dg, vec[i].en, vec[i].we, vec[i].addr, vec[i].wd,
                vec[i].irv, (vec[i].irv ? rd : 32'h0), vec[i].drv, (vec[i].drv ? rd : 32'h0)};
         check($sformatf("vec%0d", i), got, exp);
      end

      // reset in the middle of a data response
      @(negedge clk);
      inst_req   = 1'b0;
      flush      = 1'b0;
      data_req   = 1'b1;
      data_we    = 4'h0;
      data_addr  = 32'h500;
      data_wdata = 32'h0;
      #1;
      check1("rst_seq_data_gnt", data_gnt, 1'b1);
      @(negedge clk);
      data_req   = 1'b0;
      sram_rdata = 32'hbeef0001;
      #1;
      check1("rst_seq_data_rvalid", data_rvalid, 1'b1);
      data_req = 1'b1;
      #1;
      resetn = 1'b0;
      #1;
      check1("rst_async_rvalid", data_rvalid, 1'b0);
      check1("rst_gnt_forced", data_gnt, 1'b0);
      @(negedge clk);
      resetn    = 1'b1;
      data_req  = 1'b0;
      inst_req  = 1'b1;
      inst_addr = 32'h1c000100;
      #1;
      check("post_rst", {inst_gnt, sram_addr, inst_rvalid, data_rvalid},
            {1'b1, 32'h1c000100, 1'b0, 1'b0});
      @(negedge clk);
      inst_req   = 1'b0;
      sram_rdata = 32'h0badf00d;
      #1;
      check1("post_rst_inst_rvalid", inst_rvalid, 1'b1);
      check32("post_rst_inst_rdata", inst_rdata, 32'h0badf00d);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
